spi_flash_arbiter: RTL and testbench

SPI_FLASH_ARBITER -- requirements
Module: spi_flash_arbiter

---
 rtl/spi_flash_arbiter_pkg.sv | 29 ++
 rtl/spi_flash_arbiter_if.sv | 34 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/spi_flash_arbiter.sv | 134 +++++++++++++
 tb/tb_spi_flash_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_arbiter_pkg.sv
// Shared flash-subsystem definitions: arbiter states, default timing and SPI pin bundle.
package spi_flash_arbiter_pkg;

  localparam int unsigned GUARD_CYCLES_DEF = 2;
  localparam int unsigned CPU_TIMEOUT_DEF  = 4096;
  localparam int unsigned HOLD_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CPU   = 2'd1,
    ST_FT    = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic cs;
    logic sck;
    logic mosi;
  } spi_pins_t;

  // Pin state presented to the flash while nobody owns it.
  localparam spi_pins_t SPI_RELEASED = '{cs: 1'b1, sck: 1'b0, mosi: 1'b0};

  // A zero-length guard would let two masters touch the bus back to back.
  function automatic int unsigned guard_eff(input int unsigned cycles);
    return (cycles == 0) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/spi_flash_arbiter_if.sv
// Bus bundle between the SPI flash arbiter and its CPU / programmer / flash neighbours.
interface spi_flash_arbiter_if;

  logic i_cpu_req;
  logic i_cpu_spi_clk;
  logic i_cpu_spi_mosi;
  logic i_cpu_spi_cs;
  logic i_FT_CS;
  logic i_ft_spi_clk;
  logic i_ft_spi_mosi;

  logic o_SPI_CLK;
  logic o_SPI_MOSI;
  logic o_SPI_CS;
  logic o_grant_cpu;
  logic o_grant_ft;
  logic o_cpu_wait;
  logic o_timeout;

  modport slave (
    input  i_cpu_req, i_cpu_spi_clk, i_cpu_spi_mosi, i_cpu_spi_cs,
    input  i_FT_CS, i_ft_spi_clk, i_ft_spi_mosi,
    output o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
    output o_grant_cpu, o_grant_ft, o_cpu_wait, o_timeout
  );

  modport master (
    output i_cpu_req, i_cpu_spi_clk, i_cpu_spi_mosi, i_cpu_spi_cs,
    output i_FT_CS, i_ft_spi_clk, i_ft_spi_mosi,
    input  o_SPI_CLK, o_SPI_MOSI, o_SPI_CS,
    input  o_grant_cpu, o_grant_ft, o_cpu_wait, o_timeout
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (programmer CS, UART CTS).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between the CPU flash controller and an FT2232 programmer,
// with a CS-high guard gap between owners and a bounded CPU hold time.
module spi_flash_arbiter
  import spi_flash_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = GUARD_CYCLES_DEF,
  parameter int unsigned CPU_TIMEOUT  = CPU_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  spi_flash_arbiter_if.slave bus
);

  localparam int unsigned GUARD_EFF = guard_eff(GUARD_CYCLES);
  localparam int unsigned GUARD_W   = $clog2(GUARD_EFF + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(CPU_TIMEOUT - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_EFF - 1);
  localparam logic [GUARD_W-1:0] GUARD_MAX  = GUARD_W'(GUARD_EFF);

  arb_state_t         state;
  arb_state_t         next_state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GUARD_W-1:0] guard_cnt;
  logic               grant_cpu;
  logic               grant_ft;
  logic               timeout;
  logic               timeout_hit;
  logic               ft_cs_sync;
  logic               ft_req;
  spi_pins_t          pins;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_ft_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.i_FT_CS),
    .q     (ft_cs_sync)
  );

  assign ft_req = ~ft_cs_sync;

  // Ownership decisions; the programmer only wins when seen from IDLE.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ft_req) begin
          next_state = ST_FT;
        end else if (bus.i_cpu_req) begin
          next_state = ST_CPU;
        end
      end
      ST_CPU: begin
        if (hold_cnt == HOLD_LAST) begin
          next_state  = ST_GUARD;
          timeout_hit = 1'b1;
        end else if (!bus.i_cpu_req) begin
          next_state = ST_GUARD;
        end
      end
      ST_FT: begin
        if (!ft_req) begin
          next_state = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_cnt  <= '0;
      guard_cnt <= '0;
      grant_cpu <= 1'b0;
      grant_ft  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state <= next_state;

      // Grants rise one cycle after entry and drop on the same edge as the exit.
      grant_cpu <= (state == ST_CPU) && (next_state == ST_CPU);
      grant_ft  <= (state == ST_FT) && (next_state == ST_FT);

      if (timeout_hit) begin
        timeout <= 1'b1;
      end

      if ((state != ST_CPU) && (next_state == ST_CPU)) begin
        hold_cnt <= '0;
      end else if ((state == ST_CPU) && (hold_cnt != '1)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      // Saturating count; cleared whenever the FSM is outside GUARD.
      if (state != ST_GUARD) begin
        guard_cnt <= '0;
      end else if (guard_cnt != GUARD_MAX) begin
        guard_cnt <= guard_cnt + 1'b1;
      end
    end
  end

  // Flash pin mux; the programmer's CS bypasses the synchronizer so it stays bit-exact.
  always_comb begin
    pins = SPI_RELEASED;
    if (grant_cpu) begin
      pins.cs   = bus.i_cpu_spi_cs;
      pins.sck  = bus.i_cpu_spi_clk;
      pins.mosi = bus.i_cpu_spi_mosi;
    end else if (grant_ft) begin
      pins.cs   = bus.i_FT_CS;
      pins.sck  = bus.i_ft_spi_clk;
      pins.mosi = bus.i_ft_spi_mosi;
    end
  end

  assign bus.o_SPI_CS    = pins.cs;
  assign bus.o_SPI_CLK   = pins.sck;
  assign bus.o_SPI_MOSI  = pins.mosi;
  assign bus.o_grant_cpu = grant_cpu;
  assign bus.o_grant_ft  = grant_ft;
  assign bus.o_timeout   = timeout;
  assign bus.o_cpu_wait  = bus.i_cpu_req & ~grant_cpu;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scenario bench for spi_flash_arbiter: expected ownership timelines are derived from
// synchronizer latency, registered-grant latency and guard length.
module tb_spi_flash_arbiter;

  localparam int G  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  spi_flash_arbiter_if bus ();
  spi_flash_arbiter_if bus_g0 ();

  always #5 clk = ~clk;

  assign bus_g0.i_cpu_req      = bus.i_cpu_req;
  assign bus_g0.i_cpu_spi_clk  = bus.i_cpu_spi_clk;
  assign bus_g0.i_cpu_spi_mosi = bus.i_cpu_spi_mosi;
  assign bus_g0.i_cpu_spi_cs   = bus.i_cpu_spi_cs;
  assign bus_g0.i_FT_CS        = bus.i_FT_CS;
  assign bus_g0.i_ft_spi_clk   = bus.i_ft_spi_clk;
  assign bus_g0.i_ft_spi_mosi  = bus.i_ft_spi_mosi;

  spi_flash_arbiter #(.GUARD_CYCLES(G), .CPU_TIMEOUT(TO)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  spi_flash_arbiter #(.GUARD_CYCLES(0), .CPU_TIMEOUT(TO)) u_dut_g0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_g0)
  );

  // owner: 0 = nobody, 1 = CPU, 2 = programmer
  function automatic logic [2:0] exp_pins(input int owner);
    case (owner)
      1:       return {bus.i_cpu_spi_cs, bus.i_cpu_spi_clk, bus.i_cpu_spi_mosi};
      2:       return {bus.i_FT_CS, bus.i_ft_spi_clk, bus.i_ft_spi_mosi};
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [5:0] model_vec(input int owner);
    return {owner == 1, owner == 2, bus.i_cpu_req && (owner != 1), exp_pins(owner)};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {bus.o_grant_cpu, bus.o_grant_ft, bus.o_cpu_wait,
            bus.o_SPI_CS, bus.o_SPI_CLK, bus.o_SPI_MOSI};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    bus.i_cpu_spi_clk  = 1'($urandom);
    bus.i_cpu_spi_mosi = 1'($urandom);
    bus.i_cpu_spi_cs   = 1'($urandom);
    bus.i_ft_spi_clk   = 1'($urandom);
    bus.i_ft_spi_mosi  = 1'($urandom);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.i_cpu_req = 1'b0;
    bus.i_FT_CS   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got, want;
    reset         = 1'b1;
    bus.i_cpu_req = 1'b1;
    bus.i_FT_CS   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive_rand();
      tick();
      got = dut_vec(); want = model_vec(0);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL reset_pins k=%0d got %b want %b", k, got, want);
      end
      n_cmp++;
      if (bus.o_timeout !== 1'b0) begin
        n_bad++; $display("FAIL reset_timeout k=%0d got %b want 0", k, bus.o_timeout);
      end
    end
    do_reset();
  endtask

  task automatic test_cpu_grant();
    logic [5:0] got, want;
    int owner;
    do_reset();
    bus.i_cpu_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive_rand();
      tick();
      owner = (k >= 2) ? 1 : 0;
      got = dut_vec(); want = model_vec(owner);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL cpu_grant k=%0d got %b want %b", k, got, want);
      end
    end
    bus.i_cpu_req = 1'b0;
    for (int k = 1; k <= G + 2; k++) begin
      drive_rand();
      tick();
      got = dut_vec(); want = model_vec(0);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL cpu_release k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_ft_priority();
    logic [5:0] got, want;
    int owner;
    do_reset();
    bus.i_FT_CS = 1'b0;
    tick();
    tick();
    bus.i_cpu_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive_rand();
      tick();
      owner = (k >= 2) ? 2 : 0;
      got = dut_vec(); want = model_vec(owner);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ft_priority k=%0d got %b want %b", k, got, want);
      end
    end
    bus.i_FT_CS = 1'b1;
    for (int k = 1; k <= G + 7; k++) begin
      drive_rand();
      tick();
      owner = (k <= 2) ? 2 : ((k >= G + 5) ? 1 : 0);
      got = dut_vec(); want = model_vec(owner);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ft_handover k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [5:0] got, want;
    int owner;
    do_reset();
    bus.i_cpu_req = 1'b1;
    tick();
    tick();
    bus.i_FT_CS = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive_rand();
      tick();
      got = dut_vec(); want = model_vec(1);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL no_preempt k=%0d got %b want %b", k, got, want);
      end
    end
    bus.i_cpu_req = 1'b0;
    for (int k = 1; k <= G + 5; k++) begin
      drive_rand();
      tick();
      owner = (k >= G + 3) ? 2 : 0;
      got = dut_vec(); want = model_vec(owner);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL cpu_to_ft k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_timeout();
    int  phase;
    logic want_g;
    do_reset();
    bus.i_cpu_req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      drive_rand();
      tick();
      // grant windows of TO-1 cycles separated by G+2 low cycles, first rise at cycle 2
      phase  = (i - 2) % (TO - 1 + G + 2);
      want_g = (i >= 2) && (phase < TO - 1);
      n_cmp++;
      if (bus.o_grant_cpu !== want_g) begin
        n_bad++; $display("FAIL timeout_grant i=%0d got %b want %b", i, bus.o_grant_cpu, want_g);
      end
      n_cmp++;
      if (bus.o_timeout !== 1'(i >= 2 + TO - 1)) begin
        n_bad++; $display("FAIL timeout_flag i=%0d got %b want %b", i, bus.o_timeout, i >= 2 + TO - 1);
      end
    end
    bus.i_cpu_req = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    n_cmp++;
    if (bus.o_timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky got %b want 1", bus.o_timeout);
    end
    do_reset();
    n_cmp++;
    if (bus.o_timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear got %b want 0", bus.o_timeout);
    end
  endtask

  task automatic test_reset_mid_ft();
    logic [5:0] got, want;
    int owner;
    do_reset();
    bus.i_FT_CS = 1'b0;
    for (int k = 1; k <= 4; k++) tick();
    got = dut_vec(); want = model_vec(2);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL ft_before_reset got %b want %b", got, want);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = dut_vec(); want = model_vec(0);
    n_cmp++;
    if (got !== want) begin
      n_bad++; $display("FAIL reset_mid_ft got %b want %b", got, want);
    end
    for (int k = 1; k <= 5; k++) begin
      drive_rand();
      tick();
      owner = (k >= 4) ? 2 : 0;
      got = dut_vec(); want = model_vec(owner);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL ft_after_reset k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_guard_pulse();
    logic [5:0] got, want;
    do_reset();
    bus.i_cpu_req = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    bus.i_cpu_req = 1'b0;
    bus.i_FT_CS   = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive_rand();
      tick();
      bus.i_FT_CS = 1'b1;
      got = dut_vec(); want = model_vec(0);
      n_cmp++;
      if (got !== want) begin
        n_bad++; $display("FAIL guard_pulse k=%0d got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_guard_zero();
    int first_main, first_g0;
    do_reset();
    bus.i_cpu_req = 1'b1;
    for (int k = 1; k <= 3; k++) tick();
    bus.i_cpu_req = 1'b0;
    first_main = 0;
    first_g0   = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      bus.i_cpu_req = 1'b1;
      if (first_main == 0 && bus.o_grant_cpu === 1'b1) first_main = i;
      if (first_g0 == 0 && bus_g0.o_grant_cpu === 1'b1) first_g0 = i;
    end
    n_cmp++;
    if (first_main != G + 3) begin
      n_bad++; $display("FAIL regrant_guard2 got cycle %0d want %0d", first_main, G + 3);
    end
    n_cmp++;
    if (first_g0 != 4) begin
      n_bad++; $display("FAIL regrant_guard0 got cycle %0d want 4", first_g0);
    end
  endtask

  task automatic test_random_traffic();
    logic [5:0] got, want;
    int owner, len;
    do_reset();
    for (int t = 0; t < 12; t++) begin
      len = int'($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 0) begin
        bus.i_cpu_req = 1'b1;
        for (int k = 1; k <= len + 1; k++) begin
          drive_rand();
          tick();
          owner = (k >= 2) ? 1 : 0;
          got = dut_vec(); want = model_vec(owner);
          n_cmp++;
          if (got !== want) begin
            n_bad++; $display("FAIL rand_cpu t=%0d k=%0d got %b want %b", t, k, got, want);
          end
        end
        bus.i_cpu_req = 1'b0;
        for (int k = 1; k <= G + 1; k++) begin
          drive_rand();
          tick();
          got = dut_vec(); want = model_vec(0);
          n_cmp++;
          if (got !== want) begin
            n_bad++; $display("FAIL rand_cpu_gap t=%0d k=%0d got %b want %b", t, k, got, want);
          end
        end
      end else begin
        bus.i_FT_CS = 1'b0;
        for (int k = 1; k <= len + 3; k++) begin
          drive_rand();
          tick();
          owner = (k >= 4) ? 2 : 0;
          got = dut_vec(); want = model_vec(owner);
          n_cmp++;
          if (got !== want) begin
            n_bad++; $display("FAIL rand_ft t=%0d k=%0d got %b want %b", t, k, got, want);
          end
        end
        bus.i_FT_CS = 1'b1;
        for (int k = 1; k <= G + 3; k++) begin
          drive_rand();
          tick();
          owner = (k <= 2) ? 2 : 0;
          got = dut_vec(); want = model_vec(owner);
          n_cmp++;
          if (got !== want) begin
            n_bad++; $display("FAIL rand_ft_gap t=%0d k=%0d got %b want %b", t, k, got, want);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    reset              = 1'b1;
    bus.i_cpu_req      = 1'b0;
    bus.i_FT_CS        = 1'b1;
    bus.i_cpu_spi_clk  = 1'b0;
    bus.i_cpu_spi_mosi = 1'b0;
    bus.i_cpu_spi_cs   = 1'b1;
    bus.i_ft_spi_clk   = 1'b0;
    bus.i_ft_spi_mosi  = 1'b0;
    test_reset();
    test_cpu_grant();
    test_ft_priority();
    test_no_preempt();
    test_timeout();
    test_reset_mid_ft();
    test_guard_pulse();
    test_guard_zero();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
